// File: rtl/mastermind_scorer_if.sv
// Guess/score handshake between the game FSM core (master) and the Mastermind scorer (slave).
interface mastermind_scorer_if #(
   parameter int N_PEGS  = 4,
   parameter int COLOR_W = 3,
   parameter int CNT_W   = 3
);
   logic                      guess_valid;
   logic                      guess_ready;
   logic [N_PEGS*COLOR_W-1:0] guess;
   logic [N_PEGS*COLOR_W-1:0] answer;
   logic [2:0]                guess_num;
   logic                      score_valid;
   logic [CNT_W-1:0]          exact_cnt;
   logic [CNT_W-1:0]          partial_cnt;
   logic                      win;

   modport master (
      output guess_valid, guess, answer, guess_num,
      input  guess_ready, score_valid, exact_cnt, partial_cnt, win
   );

   modport slave (
      input  guess_valid, guess, answer, guess_num,
      output guess_ready, score_valid, exact_cnt, partial_cnt, win
   );
endinterface

// File: rtl/mastermind_scorer.sv
// Iterative Mastermind scorer: exact hits, then colour-only hits, plus a per-row feedback history.
// Optional macro SCORER_EARLY_WIN_EN skips the colour-only pass when every peg matched exactly.
module mastermind_scorer #(
   parameter int N_PEGS  = 4,
   parameter int COLOR_W = 3,
   parameter int N_ROWS  = 6,
   parameter int CNT_W   = 3
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   mastermind_scorer_if.slave        bus,
   input  logic                      clear_hist,
   output logic [N_ROWS*2*CNT_W-1:0] hist_flat
);
   localparam int IDX_W = (N_PEGS > 1) ? $clog2(N_PEGS) : 1;
   localparam int ROW_W = 2 * CNT_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PEGS - 1);

   typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, DONE} state_t;

   state_t                    state, state_d;
   logic [N_PEGS*COLOR_W-1:0] g_reg, a_reg;
   logic [2:0]                num_reg;
   logic [N_PEGS-1:0]         gm, gm_d, am, am_d;
   logic [IDX_W-1:0]          i_idx, i_d, j_idx, j_d;
   logic [CNT_W-1:0]          exact_w, exact_d, partial_w, partial_d;
   logic [COLOR_W-1:0]        g_peg, a_peg_i, a_peg_j;

   assign g_peg   = g_reg[i_idx*COLOR_W +: COLOR_W];
   assign a_peg_i = a_reg[i_idx*COLOR_W +: COLOR_W];
   assign a_peg_j = a_reg[j_idx*COLOR_W +: COLOR_W];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         gm        <= '0;
         am        <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
         exact_w   <= '0;
         partial_w <= '0;
         g_reg     <= '0;
         a_reg     <= '0;
         num_reg   <= '0;
      end else begin
         state     <= state_d;
         gm        <= gm_d;
         am        <= am_d;
         i_idx     <= i_d;
         j_idx     <= j_d;
         exact_w   <= exact_d;
         partial_w <= partial_d;
         if (state == IDLE && bus.guess_valid) begin
            g_reg   <= bus.guess;
            a_reg   <= bus.answer;
            num_reg <= bus.guess_num;
         end
      end
   end

   // One peg pair is examined per cycle; the match flags keep each peg from being counted twice.
   always_comb begin
      state_d         = state;
      gm_d            = gm;
      am_d            = am;
      i_d             = i_idx;
      j_d             = j_idx;
      exact_d         = exact_w;
      partial_d       = partial_w;
      bus.guess_ready = 1'b0;
      bus.score_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.guess_ready = 1'b1;
            if (bus.guess_valid) begin
               state_d   = EXACT;
               gm_d      = '0;
               am_d      = '0;
               i_d       = '0;
               j_d       = '0;
               exact_d   = '0;
               partial_d = '0;
            end
         end
         EXACT: begin
            if (g_peg == a_peg_i && g_peg != '0) begin
               gm_d[i_idx] = 1'b1;
               am_d[i_idx] = 1'b1;
               exact_d     = exact_w + CNT_W'(1);
            end
            if (i_idx == LAST_IDX) begin
               i_d = '0;
               j_d = '0;
`ifdef SCORER_EARLY_WIN_EN
               state_d = (exact_d == CNT_W'(N_PEGS)) ? DONE : PARTIAL;
`else
               state_d = PARTIAL;
`endif
            end else begin
               i_d = i_idx + IDX_W'(1);
            end
         end
         PARTIAL: begin
            if (!gm[i_idx] && !am[j_idx] && g_peg == a_peg_j && g_peg != '0) begin
               gm_d[i_idx] = 1'b1;
               am_d[j_idx] = 1'b1;
               partial_d   = partial_w + CNT_W'(1);
            end
            if (j_idx == LAST_IDX) begin
               j_d = '0;
               if (i_idx == LAST_IDX) state_d = DONE;
               else                   i_d = i_idx + IDX_W'(1);
            end else begin
               j_d = j_idx + IDX_W'(1);
            end
         end
         DONE: begin
            bus.score_valid = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Results are loaded on the edge into DONE so they are already valid alongside score_valid.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bus.exact_cnt   <= '0;
         bus.partial_cnt <= '0;
         bus.win         <= 1'b0;
         hist_flat       <= '0;
      end else begin
         if (state_d == DONE) begin
            bus.exact_cnt   <= exact_d;
            bus.partial_cnt <= partial_d;
            bus.win         <= (exact_d == CNT_W'(N_PEGS));
         end
         for (int r = 0; r < N_ROWS; r++) begin
            if (clear_hist)
               hist_flat[r*ROW_W +: ROW_W] <= '0;
            else if (state == DONE && int'(num_reg) == r)
               hist_flat[r*ROW_W +: ROW_W] <= {partial_w, exact_w};
         end
      end
   end
endmodule

// File: tb/tb_mastermind_scorer.sv
// Randomized self-checking bench for mastermind_scorer against a colour-counting Mastermind model.
module tb_mastermind_scorer;
   localparam int N_PEGS  = 4;
   localparam int COLOR_W = 3;
   localparam int N_ROWS  = 6;
   localparam int CNT_W   = 3;
   localparam int GW      = N_PEGS * COLOR_W;
   localparam int HW      = N_ROWS * 2 * CNT_W;
   localparam int N_COLS  = 1 << COLOR_W;

   logic          Clk        = 1'b0;
   logic          Reset_n    = 1'b0;
   logic          clear_hist = 1'b0;
   logic [HW-1:0] hist_flat;

   int err_count   = 0;
   int check_count = 0;
   logic [2*CNT_W-1:0] hist_model [N_ROWS];

   mastermind_scorer_if #(.N_PEGS(N_PEGS), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) bus ();

   mastermind_scorer #(.N_PEGS(N_PEGS), .COLOR_W(COLOR_W), .N_ROWS(N_ROWS), .CNT_W(CNT_W)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .bus        (bus),
      .clear_hist (clear_hist),
      .hist_flat  (hist_flat)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Standard Mastermind rule: exact hits, then per colour the smaller of the leftover counts.
   function automatic void refScore(input logic [GW-1:0] g, input logic [GW-1:0] a,
                                    output int ex, output int pa);
      int gc [N_COLS];
      int ac [N_COLS];
      ex = 0;
      pa = 0;
      for (int c = 0; c < N_COLS; c++) begin
         gc[c] = 0;
         ac[c] = 0;
      end
      for (int p = 0; p < N_PEGS; p++) begin
         int gp;
         int ap;
         gp = int'(g[p*COLOR_W +: COLOR_W]);
         ap = int'(a[p*COLOR_W +: COLOR_W]);
         if (gp != 0 && gp == ap) ex++;
         else begin
            if (gp != 0) gc[gp]++;
            ac[ap]++;
         end
      end
      for (int c = 1; c < N_COLS; c++) pa += (gc[c] < ac[c]) ? gc[c] : ac[c];
   endfunction

   function automatic logic [HW-1:0] histExpected();
      logic [HW-1:0] h;
      h = '0;
      for (int r = 0; r < N_ROWS; r++) h[r*2*CNT_W +: 2*CNT_W] = hist_model[r];
      return h;
   endfunction

   task automatic applyStimulus(input logic [GW-1:0] g, input logic [GW-1:0] a, input logic [2:0] num,
                                input bit hold, input bit clr_at_done);
      int ex, pa, exp_lat, first_k, pulses, ready_bad;
      logic [CNT_W-1:0] got_ex, got_pa;
      logic got_win;
      refScore(g, a, ex, pa);
      exp_lat = 1 + N_PEGS + N_PEGS * N_PEGS;
`ifdef SCORER_EARLY_WIN_EN
      if (ex == N_PEGS) exp_lat = 1 + N_PEGS;
`endif
      @(negedge Clk);
      checkOutput("ready_idle", 64'(bus.guess_ready), 64'(1));
      bus.guess       = g;
      bus.answer      = a;
      bus.guess_num   = num;
      bus.guess_valid = 1'b1;
      @(posedge Clk);
      #1;
      if (!hold) bus.guess_valid = 1'b0;
      first_k   = 0;
      pulses    = 0;
      ready_bad = 0;
      got_ex    = '0;
      got_pa    = '0;
      got_win   = 1'b0;
      for (int k = 1; k <= exp_lat + 2; k++) begin
         @(negedge Clk);
         if (bus.score_valid) begin
            pulses++;
            if (first_k == 0) begin
               first_k = k;
               got_ex  = bus.exact_cnt;
               got_pa  = bus.partial_cnt;
               got_win = bus.win;
            end
         end
         if ((k <= exp_lat) == bus.guess_ready) ready_bad++;
         if (hold) begin
            if (k >= exp_lat) bus.guess_valid = 1'b0;
            else begin
               bus.guess     = GW'($urandom);
               bus.answer    = GW'($urandom);
               bus.guess_num = 3'($urandom);
            end
         end
         if (clr_at_done) clear_hist = (k == exp_lat);
      end
      checkOutput("latency", 64'(first_k), 64'(exp_lat));
      checkOutput("pulses", 64'(pulses), 64'(1));
      checkOutput("ready_window", 64'(ready_bad), 64'(0));
      checkOutput("exact", 64'(got_ex), 64'(ex));
      checkOutput("partial", 64'(got_pa), 64'(pa));
      checkOutput("win", 64'(got_win), 64'(ex == N_PEGS));
      checkOutput("exact_hold", 64'(bus.exact_cnt), 64'(ex));
      if (clr_at_done) begin
         for (int r = 0; r < N_ROWS; r++) hist_model[r] = '0;
      end else if (int'(num) < N_ROWS) begin
         hist_model[num] = {CNT_W'(pa), CNT_W'(ex)};
      end
      checkOutput("hist", 64'(hist_flat), 64'(histExpected()));
   endtask

   function automatic logic [GW-1:0] randCode(input int max_col);
      logic [GW-1:0] c;
      c = '0;
      for (int p = 0; p < N_PEGS; p++) c[p*COLOR_W +: COLOR_W] = COLOR_W'($urandom_range(max_col, 0));
      return c;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [GW-1:0] g, a;
      bus.guess_valid = 1'b0;
      bus.guess       = '0;
      bus.answer      = '0;
      bus.guess_num   = '0;
      for (int r = 0; r < N_ROWS; r++) hist_model[r] = '0;

      repeat (3) @(negedge Clk);
      checkOutput("rst_ready", 64'(bus.guess_ready), 64'(1));
      checkOutput("rst_score_valid", 64'(bus.score_valid), 64'(0));
      checkOutput("rst_exact", 64'(bus.exact_cnt), 64'(0));
      checkOutput("rst_partial", 64'(bus.partial_cnt), 64'(0));
      checkOutput("rst_win", 64'(bus.win), 64'(0));
      checkOutput("rst_hist", 64'(hist_flat), 64'(0));
      Reset_n = 1'b1;

      applyStimulus(12'b001_001_001_001, 12'b001_001_001_001, 3'd0, 1'b0, 1'b0);
      applyStimulus(12'b001_010_011_100, 12'b100_011_010_001, 3'd1, 1'b0, 1'b0);
      applyStimulus(12'b001_001_001_001, 12'b010_010_001_001, 3'd2, 1'b0, 1'b0);
      applyStimulus(12'b010_010_001_001, 12'b001_001_010_010, 3'd4, 1'b0, 1'b0);
      applyStimulus(12'b000_000_000_000, 12'b000_000_000_000, 3'd3, 1'b0, 1'b0);
      applyStimulus(12'b101_110_111_011, 12'b101_110_111_011, 3'd5, 1'b0, 1'b0);
      checkOutput("row5", 64'(hist_flat[35:30]), 64'(6'b000_100));
      applyStimulus(12'b011_001_010_100, 12'b001_011_010_110, 3'd7, 1'b0, 1'b0);
      applyStimulus(randCode(3), randCode(3), 3'd1, 1'b1, 1'b0);

      @(negedge Clk);
      clear_hist = 1'b1;
      @(negedge Clk);
      clear_hist = 1'b0;
      for (int r = 0; r < N_ROWS; r++) hist_model[r] = '0;
      checkOutput("clear_hist", 64'(hist_flat), 64'(0));

      applyStimulus(12'b001_001_001_001, 12'b001_001_001_001, 3'd2, 1'b0, 1'b0);
      applyStimulus(12'b010_001_001_011, 12'b001_010_011_011, 3'd0, 1'b0, 1'b1);

      // Abort a score mid-flight with an asynchronous reset.
      applyStimulus(12'b110_110_110_110, 12'b110_110_110_110, 3'd4, 1'b0, 1'b0);
      @(negedge Clk);
      bus.guess       = 12'b001_010_011_100;
      bus.answer      = 12'b001_010_011_100;
      bus.guess_num   = 3'd0;
      bus.guess_valid = 1'b1;
      @(posedge Clk);
      #1;
      bus.guess_valid = 1'b0;
      repeat (10) @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      for (int r = 0; r < N_ROWS; r++) hist_model[r] = '0;
      checkOutput("midrst_ready", 64'(bus.guess_ready), 64'(1));
      checkOutput("midrst_score_valid", 64'(bus.score_valid), 64'(0));
      checkOutput("midrst_exact", 64'(bus.exact_cnt), 64'(0));
      checkOutput("midrst_partial", 64'(bus.partial_cnt), 64'(0));
      checkOutput("midrst_win", 64'(bus.win), 64'(0));
      checkOutput("midrst_hist", 64'(hist_flat), 64'(0));
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         checkOutput("midrst_no_score", 64'(bus.score_valid), 64'(0));
      end
      Reset_n = 1'b1;
      applyStimulus(12'b001_010_011_100, 12'b100_010_001_011, 3'd2, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         g = randCode(($urandom_range(1, 0) == 1) ? 3 : 7);
         a = randCode(($urandom_range(1, 0) == 1) ? 3 : 7);
         if (n % 7 == 3) a = g;
         applyStimulus(g, a, 3'($urandom_range(7, 0)), bit'($urandom_range(3, 0) == 0),
                       bit'($urandom_range(9, 0) == 0));
      end

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end
endmodule
